// File: rtl/fix_recursion_bank_pkg.sv
// Shared fixed-point types for the lookback recursion bank: state word,
// complex pair, bank FSM states and saturation limits.
package fix_recursion_bank_pkg;

  localparam int unsigned N_INT  = 9;
  localparam int unsigned N_MANT = 15;
  localparam int unsigned FIX_W  = N_INT + N_MANT + 1;

  typedef logic signed [FIX_W-1:0] fix_t;

  typedef struct packed {
    fix_t re;
    fix_t im;
  } cplx_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam fix_t FIX_MAX = {1'b0, {(FIX_W-1){1'b1}}};
  localparam fix_t FIX_MIN = {1'b1, {(FIX_W-1){1'b0}}};

endpackage

// File: rtl/fix_recursion_bank_cmult.sv
// fix_cmult_pipe: complex multiply (s*L) with floor shift by N_MANT and a
// STAGES-deep register pipeline carrying a valid bit and a channel tag.
module fix_cmult_pipe
  import fix_recursion_bank_pkg::*;
#(
  parameter int unsigned W      = FIX_W,
  parameter int unsigned N_MANT = 15,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 2
) (
  input  logic                 clkRecurse,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic signed [W-1:0]  a_re,
  input  logic signed [W-1:0]  a_im,
  input  logic signed [W-1:0]  b_re,
  input  logic signed [W-1:0]  b_im,
  output logic                 out_valid,
  output logic [TAG_W-1:0]     out_tag,
  output logic signed [2*W:0]  p_re,
  output logic signed [2*W:0]  p_im
);

  localparam int unsigned MW = 2 * W;
  localparam int unsigned PW = 2 * W + 1;

  logic signed [MW-1:0] m_rr, m_ii, m_ir, m_ri;
  logic signed [PW-1:0] re_c, im_c;

  logic [STAGES-1:0]            vld_d, vld_q;
  logic [STAGES-1:0][TAG_W-1:0] tag_d, tag_q;
  logic [STAGES-1:0][PW-1:0]    re_d, re_q, im_d, im_q;

  // Full-precision products; the shift floors because the sums are signed.
  always_comb begin
    m_rr = MW'(a_re) * MW'(b_re);
    m_ii = MW'(a_im) * MW'(b_im);
    m_ir = MW'(a_im) * MW'(b_re);
    m_ri = MW'(a_re) * MW'(b_im);
    re_c = (PW'(m_rr) - PW'(m_ii)) >>> N_MANT;
    im_c = (PW'(m_ir) + PW'(m_ri)) >>> N_MANT;

    vld_d[0] = in_valid;
    tag_d[0] = in_tag;
    re_d[0]  = re_c;
    im_d[0]  = im_c;
    for (int unsigned s = 1; s < STAGES; s++) begin
      vld_d[s] = vld_q[s-1];
      tag_d[s] = tag_q[s-1];
      re_d[s]  = re_q[s-1];
      im_d[s]  = im_q[s-1];
    end
  end

  always_ff @(posedge clkRecurse) begin
    if (!rst) begin
      vld_q <= '0;
      tag_q <= '0;
      re_q  <= '0;
      im_q  <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      re_q  <= re_d;
      im_q  <= im_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign p_re      = re_q[STAGES-1];
  assign p_im      = im_q[STAGES-1];

endmodule

// File: rtl/fix_recursion_bank.sv
// Channel-serial bank of complex recursions s_c <= L_c*s_c + u_c sharing one
// pipelined multiplier. Define RECURSION_SATURATE_EN to saturate the final add.
module fix_recursion_bank
  import fix_recursion_bank_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned n_int       = N_INT,
  parameter int unsigned n_mant      = N_MANT,
  parameter int unsigned MULT_STAGES = 2,
  parameter logic [NCH-1:0][n_int+n_mant:0] FACT_R = '0,
  parameter logic [NCH-1:0][n_int+n_mant:0] FACT_I = '0
) (
  input  logic                                clkRecurse,
  input  logic                                rst,
  input  logic                                clr,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NCH*(n_int+n_mant+1)-1:0]     inR,
  input  logic [NCH*(n_int+n_mant+1)-1:0]     inI,
  output logic                                out_valid,
  output logic [NCH*(n_int+n_mant+1)-1:0]     outR,
  output logic [NCH*(n_int+n_mant+1)-1:0]     outI
);

  localparam int unsigned W    = n_int + n_mant + 1;
  localparam int unsigned PW   = 2 * W + 1;
  localparam int unsigned SW   = PW + 1;
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned DR_W = (MULT_STAGES > 1) ? $clog2(MULT_STAGES) : 1;

  state_e                  state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [DR_W-1:0]         drn_q, drn_d;
  logic [NCH-1:0][W-1:0]   ubr_q, ubr_d, ubi_q, ubi_d;
  logic [NCH-1:0][W-1:0]   sr_q, sr_d, si_q, si_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;

  logic                    issue_c;
  logic signed [W-1:0]     op_re, op_im, fac_re, fac_im;
  logic                    pv;
  logic [CH_W-1:0]         ptag;
  logic signed [PW-1:0]    p_re, p_im;
  logic signed [W-1:0]     u_re, u_im, wb_re, wb_im;
  logic signed [SW-1:0]    sum_re, sum_im;

  // Reduce the exact sum to a state word: clamp or two's-complement wrap.
  function automatic logic signed [W-1:0] fold(input logic signed [SW-1:0] s);
`ifdef RECURSION_SATURATE_EN
    if (s > SW'(FIX_MAX))      return FIX_MAX;
    else if (s < SW'(FIX_MIN)) return FIX_MIN;
    else                       return W'(s);
`else
    return W'(s);
`endif
  endfunction

  always_comb begin
    op_re  = sr_q[ch_q];
    op_im  = si_q[ch_q];
    fac_re = FACT_R[ch_q];
    fac_im = FACT_I[ch_q];
    u_re   = ubr_q[ptag];
    u_im   = ubi_q[ptag];
    sum_re = SW'(p_re) + SW'(u_re);
    sum_im = SW'(p_im) + SW'(u_im);
    wb_re  = fold(sum_re);
    wb_im  = fold(sum_im);
  end

  fix_cmult_pipe #(
    .W      (W),
    .N_MANT (n_mant),
    .STAGES (MULT_STAGES),
    .TAG_W  (CH_W)
  ) u_cmult (
    .clkRecurse (clkRecurse),
    .rst        (rst),
    .in_valid   (issue_c),
    .in_tag     (ch_q),
    .a_re       (op_re),
    .a_im       (op_im),
    .b_re       (fac_re),
    .b_im       (fac_im),
    .out_valid  (pv),
    .out_tag    (ptag),
    .p_re       (p_re),
    .p_im       (p_im)
  );

  // Next-state, channel scheduling and per-channel writeback.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    drn_d   = drn_q;
    ubr_d   = ubr_q;
    ubi_d   = ubi_q;
    sr_d    = sr_q;
    si_d    = si_q;
    issue_c = 1'b0;

    if (pv) begin
      sr_d[ptag] = wb_re;
      si_d[ptag] = wb_im;
    end

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          ubr_d   = inR;
          ubi_d   = inI;
          ch_d    = '0;
          state_d = RUN;
        end else if (clr) begin
          sr_d = '0;
          si_d = '0;
        end
      end
      RUN: begin
        issue_c = 1'b1;
        if (ch_q == CH_W'(NCH - 1)) begin
          ch_d    = '0;
          drn_d   = '0;
          state_d = DRAIN;
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
      DRAIN: begin
        if (drn_q == DR_W'(MULT_STAGES - 1)) state_d = DONE;
        else                                 drn_d   = drn_q + DR_W'(1);
      end
      DONE: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clkRecurse) begin
    if (!rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      drn_q       <= '0;
      ubr_q       <= '0;
      ubi_q       <= '0;
      sr_q        <= '0;
      si_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      drn_q       <= drn_d;
      ubr_q       <= ubr_d;
      ubi_q       <= ubi_d;
      sr_q        <= sr_d;
      si_q        <= si_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign outR      = sr_q;
  assign outI      = si_q;

endmodule

// File: tb/tb_fix_recursion_bank.sv
// Directed bench for fix_recursion_bank: four channels with distinct factors
// (decay, rotation, near-unity overflow, mixed complex) driven from a table.
module tb_fix_recursion_bank;
  import fix_recursion_bank_pkg::*;

  localparam int unsigned NCH = 4;
  localparam int unsigned W   = FIX_W;
  localparam int unsigned MS  = 2;
  localparam int          LAT = NCH + MS + 1;
  localparam int          PER = NCH + MS + 2;

  localparam logic [NCH-1:0][W-1:0] FR = {W'(16384), W'(32767), W'(0), W'(16384)};
  localparam logic [NCH-1:0][W-1:0] FI = {W'(16384), W'(0), W'(32768), W'(0)};

`ifdef RECURSION_SATURATE_EN
  localparam int EXP_OVF = int'(FIX_MAX);
`else
  localparam int EXP_OVF = -8389376;
`endif

  logic               clkRecurse = 1'b0;
  logic               rst, clr, in_valid;
  logic               in_ready, out_valid;
  logic [NCH*W-1:0]   inR, inI, outR, outI;

  fix_recursion_bank #(
    .NCH         (NCH),
    .n_int       (N_INT),
    .n_mant      (N_MANT),
    .MULT_STAGES (MS),
    .FACT_R      (FR),
    .FACT_I      (FI)
  ) dut (
    .clkRecurse (clkRecurse),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inR        (inR),
    .inI        (inI),
    .out_valid  (out_valid),
    .outR       (outR),
    .outI       (outI)
  );

  always #5 clkRecurse = ~clkRecurse;

  typedef struct packed {
    logic [NCH-1:0][31:0] ur;
    logic [NCH-1:0][31:0] ui;
    logic [NCH-1:0][31:0] er;
    logic [NCH-1:0][31:0] ei;
  } vec_t;

  vec_t tbl [3];
  vec_t zero_v;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    fix_t t;
    t = v;
    return int'(t);
  endfunction

  task automatic drive_vec(input vec_t v);
    for (int c = 0; c < NCH; c++) begin
      inR[W*c +: W] = W'(v.ur[c]);
      inI[W*c +: W] = W'(v.ui[c]);
    end
  endtask

  task automatic chk_vec(input string tag, input vec_t v);
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("%s re ch%0d", tag, c), sx(outR[W*c +: W]), $signed(v.er[c]));
      chk($sformatf("%s im ch%0d", tag, c), sx(outI[W*c +: W]), $signed(v.ei[c]));
    end
  endtask

  // Accept one vector, then count cycles until out_valid (bounded).
  task automatic send(input string tag, input vec_t v);
    int  lat;
    bit  seen;
    @(negedge clkRecurse);
    drive_vec(v);
    in_valid = 1'b1;
    chk($sformatf("%s in_ready", tag), int'(in_ready), 1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 30) begin
      @(negedge clkRecurse);
      lat++;
      if (lat == 1) in_valid = 1'b0;
      seen = out_valid;
    end
    chk($sformatf("%s latency", tag), lat, LAT);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, ov, last_acc, ov_cnt;

    zero_v = '0;
    tbl[0].ur = {32'(1000), 32'(8388608), 32'(32768), 32'(32768)};
    tbl[0].ui = {32'(-2000), 32'(0), 32'(0), 32'(-1)};
    tbl[0].er = tbl[0].ur;
    tbl[0].ei = tbl[0].ui;
    tbl[1].ur = {32'(1000), 32'(8388608), 32'(0), 32'(32768)};
    tbl[1].ui = {32'(-2000), 32'(0), 32'(0), 32'(-1)};
    tbl[1].er = {32'(2500), 32'(16776960), 32'(0), 32'(49152)};
    tbl[1].ei = {32'(-2500), 32'(0), 32'(32768), 32'(-2)};
    tbl[2].ur = tbl[1].ur;
    tbl[2].ui = tbl[1].ui;
    tbl[2].er = {32'(3500), 32'(EXP_OVF), 32'(-32768), 32'(57344)};
    tbl[2].ei = {32'(-2000), 32'(0), 32'(0), 32'(-2)};

    // Reset held with in_valid asserted.
    rst = 1'b0; clr = 1'b0; in_valid = 1'b1;
    inR = '1; inI = '1;
    repeat (3) begin
      @(posedge clkRecurse);
      @(negedge clkRecurse);
      chk("reset in_ready", int'(in_ready), 0);
      chk("reset out_valid", int'(out_valid), 0);
    end
    chk("reset outR zero", int'(|outR), 0);
    chk("reset outI zero", int'(|outI), 0);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clkRecurse);
    chk("post-reset in_ready", int'(in_ready), 1);
    chk("post-reset out_valid", int'(out_valid), 0);

    // Decay / rotation / overflow / mixed vectors from the table.
    for (int v = 0; v < 3; v++) begin
      send($sformatf("vec%0d", v), tbl[v]);
      chk_vec($sformatf("vec%0d", v), tbl[v]);
      @(negedge clkRecurse);
      chk($sformatf("vec%0d pulse width", v), int'(out_valid), 0);
    end

    // in_valid held high: one acceptance per PER cycles, no extra out_valid.
    @(negedge clkRecurse);
    drive_vec(zero_v);
    in_valid = 1'b1;
    acc = 0; ov = 0; last_acc = -1;
    for (int i = 0; i < 4 * PER; i++) begin
      if (in_ready) begin
        if (acc > 0) chk("busy spacing", i - last_acc, PER);
        last_acc = i;
        acc++;
      end
      if (out_valid) ov++;
      @(negedge clkRecurse);
    end
    in_valid = 1'b0;
    chk("busy accepts", acc, 4);
    chk("busy out_valid count", ov, 4);

    // Reset while channel 2 is being issued.
    drive_vec(tbl[1]);
    in_valid = 1'b1;
    @(negedge clkRecurse);
    in_valid = 1'b0;
    repeat (2) @(negedge clkRecurse);
    rst = 1'b0;
    @(negedge clkRecurse);
    rst = 1'b1;
    ov_cnt = 0;
    repeat (12) begin
      @(negedge clkRecurse);
      if (out_valid) ov_cnt++;
    end
    chk("midrst out_valid", ov_cnt, 0);
    chk("midrst states zero", int'(|{outR, outI}), 0);
    send("midrst restart", tbl[0]);
    chk_vec("midrst restart", tbl[0]);

    // Clear in IDLE.
    @(negedge clkRecurse);
    clr = 1'b1;
    @(negedge clkRecurse);
    clr = 1'b0;
    chk("clr states zero", int'(|{outR, outI}), 0);
    chk("clr out_valid", int'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fix_recursion_bank.md
Name: fix_recursion_bank

Overview:
- Time-multiplexed bank of NCH first-order complex fixed-point recursions, s_c[k+1] = L_c·s_c[k] + u_c[k].
- All channels share one pipelined complex multiply-add unit.
- Sits in the lookback path of the hybrid filter, in the clkRecurse domain, between the per-channel input LUTs and the output weighting stage.
- Successor to the single-channel recursion module: generalises channel count and multiplier pipelining, and adds a valid/ready handshake, channel-serial scheduling and a synchronous state clear.

Parameters:
- NCH, 4, number of complex recursion channels (≥1).
- n_int, 9, integer bits of state/input/factor.
- n_mant, 15, fractional bits.
- MULT_STAGES, 2, register stages inside the complex multiplier (≥1).
- FACT_R, 0, packed [NCH-1:0][n_int+n_mant:0] real part of L_c.
- FACT_I, 0, packed [NCH-1:0][n_int+n_mant:0] imaginary part of L_c.

Ports:
- clkRecurse  in  1  recursion clock.
- rst  in  1  reset, synchronous, active-low.
- clr  in  1  synchronous state clear, active-high, only honoured in IDLE.
- in_valid  in  1  input vector valid.
- in_ready  out  1  bank can accept a vector.
- inR  in  NCH*W  real inputs u_c; channel c at [W*c +: W], W = n_int+n_mant+1.
- inI  in  NCH*W  imaginary inputs u_c.
- out_valid  out  1  one-cycle pulse; outR/outI hold new states.
- outR  out  NCH*W  real states s_c, same packing as inR.
- outI  out  NCH*W  imaginary states s_c.

Behaviour:
- Reset (rst=0 at posedge):
  - all states 0, outR/outI 0, out_valid 0, FSM to IDLE.
  - Multiplier pipeline contents are discarded.
  - Takes effect mid-operation: a partially updated vector is lost; no out_valid follows.
- FSM states and transitions:
  - IDLE: in_ready=1.
    - in_valid=1: latch inR/inI into an input buffer, channel counter ch=0, go to RUN.
    - else if clr=1: zero all states and outputs; stay IDLE.
    - in_valid and clr both set: accept the vector, ignore clr.
  - RUN: issue channel ch to the multiplier each cycle (operand s_ch, factor L_ch); ch++. After ch=NCH-1 go to DRAIN.
  - DRAIN: wait MULT_STAGES cycles for the last product.
  - DONE: out_valid=1 for exactly this cycle; next state IDLE.
- Writeback:
  - Product of channel c emerges MULT_STAGES cycles after issue.
  - Add u_c from the input buffer and write s_c the same cycle.
  - outR/outI update channel-by-channel during RUN/DRAIN; they are only guaranteed coherent while out_valid=1 and until the next acceptance.
- in_ready=0 in RUN/DRAIN/DONE. in_valid there is ignored and is not queued.
- Latency: acceptance edge to out_valid = NCH+MULT_STAGES+1 cycles. Max throughput is one vector per NCH+MULT_STAGES+2 cycles.
- Channels are independent, so there are no read-after-write hazards inside a vector. The state read for vector k+1 always sees the writeback from vector k.
- Arithmetic:
  - Real part = (sR·LR − sI·LI); imaginary part = (sI·LR + sR·LI).
  - Full-precision 2W products, arithmetic shift right by n_mant (floor), then add u.
  - Overflow wraps (two's complement) to W bits.
- NCH=1: RUN lasts one cycle.

Optional Feature:
- Macro RECURSION_SATURATE_EN.
- Defined: the final add saturates to [−2^(W−1), 2^(W−1)−1] per component.
- Not defined: wrap-around as above.
- Latency, handshake and reset are identical in both builds.

Decomposition:
- The shared fixed-point package holds:
  - the W-bit signed state type;
  - a complex pair struct {re, im};
  - the FSM state enum {IDLE, RUN, DRAIN, DONE};
  - saturation limit constants derived from n_int/n_mant.
- One sub-module, fix_cmult_pipe: complex multiplier with MULT_STAGES registers, valid and channel-tag passthrough. The bank instantiates it once.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 → in_ready=0 during reset, then 1; out_valid=0; outputs 0.
- Decay, NCH=4, MULT_STAGES=2, n_mant=15, FACT_R[c]=16384 (0.5), FACT_I=0:
  - inputs u_c=32768 (1.0) on consecutive accepts.
  - States: 32768, 49152, 57344.
  - out_valid exactly 7 cycles after each acceptance.
- Rotation, FACT_R=0, FACT_I=32768 (j):
  - s=(32768,0), u=0 → (0,32768) → (−32768,0).
- Busy input: in_valid held high across RUN → exactly one vector accepted per NCH+MULT_STAGES+2 cycles; no extra out_valid.
- Mid-operation reset: rst=0 in RUN at ch=2 → no out_valid, all states 0, next vector starts from zero state. Separately, clr=1 in IDLE → states 0.
- Overflow: FACT_R=32767, s=u=2^23 → wraps negative without RECURSION_SATURATE_EN; equals 2^24−1 with it.
